// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MIN_N = 2;
  localparam int MAX_N = 32;

  // Bit-index counter width; counts 0..n-1.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder built from two half adders and an OR of their carries.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  half_adder u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell reused over N cycles,
// LSB first, behind a start/busy/done handshake.

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int N  = 8,
  localparam int CW = cw(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (N < MIN_N || N > MAX_N) begin : g_bad_n
    $fatal(1, "serial_add_ctrl: N=%0d outside %0d..%0d", N, MIN_N, MAX_N);
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  sa_q,    sa_d;
  logic [N-1:0]  sb_q,    sb_d;
  logic [N-1:0]  ss_q,    ss_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  sum_q,   sum_d;
  logic          cout_q,  cout_d;

  logic fa_s, fa_co;

  fa_cell u_fa (
    .x (sa_q[0]),
    .y (sb_q[0]),
    .ci(carry_q),
    .s (fa_s),
    .co(fa_co)
  );

  // Next-state: sequencing, shifting and result capture on the last bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ss_d    = ss_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ss_d    = {fa_s, ss_q[N-1:1]};
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = fa_co;
        if (cnt_q == LAST) begin
          // Publish the full word including the bit computed this edge;
          // cnt stays at N-1 so it never wraps.
          sum_d   = {fa_s, ss_q[N-1:1]};
          cout_d  = fa_co;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      ss_q    <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ss_q    <= ss_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: table vectors, hand sequences for the
// multi-cycle corners, random operations, and a cycle-level reference model.
`timescale 1ns/1ps
module tb_serial_add_ctrl;

  localparam int N8 = 8;
  localparam int N4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=8 instance
  logic          start8, cin8, busy8, done8, cout8;
  logic [N8-1:0] a8, b8, sum8;
  // N=4 instance
  logic          start4, cin4, busy4, done4, cout4;
  logic [N4-1:0] a4, b4, sum4;

  serial_add_ctrl #(.N(N8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.N(N4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model for the N=8 instance: an operation accepted in idle
  // occupies N+2 cycles; the result appears when N+1 edges have passed.
  int          rem = 0;
  logic [8:0]  m_exp = '0;
  logic [7:0]  m_sum = '0;
  logic        m_cout = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      rem = 0; m_sum = '0; m_cout = 1'b0;
    end else if (rem == 0) begin
      if (start8) begin
        rem   = N8 + 1;
        m_exp = 9'(a8) + 9'(b8) + 9'(cin8);
      end
    end else begin
      rem--;
      if (rem == 1) {m_cout, m_sum} = m_exp;
    end
    #1;
    if (chk_en) begin
      check("model_busy", 64'(busy8), 64'(rem > 1));
      check("model_done", 64'(done8), 64'(rem == 1));
      check("model_sum",  64'(sum8),  64'(m_sum));
      check("model_cout", 64'(cout8), 64'(m_cout));
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  // Start an N=8 op, check busy, latency, result and single-cycle done.
  task automatic run_op(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] es, input logic ec);
    int lat;
    bit seen;
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
    @(negedge clk);
    start8 = 1'b0; a8 = $urandom; b8 = $urandom; cin8 = 1'($urandom);
    check({nm, "_busy"}, 64'(busy8), 64'd1);
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (done8) begin seen = 1'b1; lat = i; end
    end
    check({nm, "_done_seen"}, 64'(seen), 64'd1);
    check({nm, "_latency"}, 64'(lat), 64'(N8));
    check({nm, "_sum"}, 64'(sum8), 64'(es));
    check({nm, "_cout"}, 64'(cout8), 64'(ec));
    @(negedge clk);
    check({nm, "_done_1cyc"}, 64'(done8), 64'd0);
  endtask

  vec_t vt[4];

  initial begin
    logic [8:0] r;
    logic [7:0] ra, rb;
    logic       rc;
    int         ndone, last_d;
    bit         any_done;

    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};

    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_sum",  64'(sum8),  64'd0);
    check("rst_cout", 64'(cout8), 64'd0);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 4; i++)
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].sum, vt[i].cout);

    // Result holds over idle cycles (last op FF+FF+1 style check)
    run_op("hold_op", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_sum", 64'(sum8), 64'hFF);
      check("hold_cout", 64'(cout8), 64'd1);
    end

    // Start during RUN is ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 20 && !any_done; i++) begin
      @(negedge clk);
      if (done8) any_done = 1'b1;
    end
    check("ign_done_seen", 64'(any_done), 64'd1);
    check("ign_sum", 64'(sum8), 64'h30);
    check("ign_cout", 64'(cout8), 64'd0);

    // Reset mid-RUN aborts with no done pulse
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    check("abort_sum",  64'(sum8),  64'd0);
    check("abort_cout", 64'(cout8), 64'd0);
    any_done = 1'b0;
    for (int i = 0; i < N8 + 3; i++) begin
      @(negedge clk);
      if (done8) any_done = 1'b1;
    end
    check("abort_no_done", 64'(any_done), 64'd0);
    run_op("post_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // Randomized operations; expected value from plain arithmetic
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      r  = 9'(ra) + 9'(rb) + 9'(rc);
      run_op("rand", ra, rb, rc, r[7:0], r[8]);
    end

    // N=4 back-to-back with start held high
    @(negedge clk);
    start4 = 1'b1; a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1;
    ndone = 0; last_d = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done4) begin
        r = 9'(a4) + 9'(b4) + 9'(cin4);
        check("n4_sum", 64'(sum4), 64'(r[3:0]));
        check("n4_cout", 64'(cout4), 64'(r[4]));
        if (last_d >= 0) check("n4_period", 64'(c - last_d), 64'(N4 + 2));
        last_d = c;
        ndone++;
      end
    end
    start4 = 1'b0;
    check("n4_pulses", 64'(ndone >= 4), 64'd1);

    repeat (8) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial N-bit adder controller.
- Time-shares one full-adder cell over N cycles instead of instantiating N parallel cells. The cell is two half_adder instances plus an OR gate.
- Sequences operand shifting, carry feedback and result capture behind a start/busy/done handshake.
- Sits between a requester (testbench or top-level FSM) and the structural adder cells; trades area for latency.

Parameters:
- N, 8, operand and result width in bits; legal range 2..32.
- CW, $clog2(N), bit-index counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  operand A; sampled on the accepting edge.
- b  input  N  operand B; sampled on the accepting edge.
- cin  input  1  carry-in; sampled on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse while in DONE.
- sum  output  N  registered result; updated only on completion.
- cout  output  1  registered carry-out; updated only on completion.

Behaviour:
- Reset: on a clk edge with rst=1, all of the following are cleared:
  - state=IDLE, cnt=0.
  - Internal shift registers cleared; carry flop cleared.
  - busy=0, done=0, sum=0, cout=0.
  - rst overrides start in the same cycle.
- States: IDLE, RUN, DONE. Encodings come from the package.
- IDLE:
  - start=0: hold. sum and cout keep their last result.
  - start=1 at edge k:
    - a and b load into shift registers sa and sb.
    - cin loads into the carry flop; cnt=0; state=RUN; busy=1 from edge k.
- RUN, each edge:
  - Cell inputs are sa[0], sb[0], carry.
  - Cell sum bit shifts into the MSB of internal register ss; ss shifts right.
  - Cell carry-out loads the carry flop.
  - sa and sb shift right; cnt increments.
- RUN exit:
  - The edge with cnt==N-1 processes bit N-1 (edge k+N).
  - On that edge: sum<=final ss value including the bit just computed; cout<=carry-out of bit N-1.
  - state=DONE, busy=0, done=1.
- DONE: lasts exactly one cycle. Next edge gives state=IDLE, done=0.
- Latency: done is high in the cycle after edge k+N, and sum/cout are valid from that same edge.
- Throughput: a new start is accepted no earlier than edge k+N+2. With start held high, one operation completes every N+2 cycles.
- start in RUN or DONE is ignored. It is not queued, and a, b, cin are not resampled.
- a, b, cin may change freely after the accepting edge.
- sum and cout never show partial results. They change only on the RUN-exit edge and on reset.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(N+1).
- No overflow flag; signed interpretation is left to the consumer.
- Counter: cnt never exceeds N-1. No wrap occurs within a run, and cnt is cleared on acceptance.
- Reset mid-RUN: the operation is aborted, all outputs clear as above, and no done pulse is emitted.
- Illegal state encoding: return to IDLE on the next edge with busy=0 and done=0.

Decomposition:
- Package serial_add_pkg:
  - State enum {IDLE, RUN, DONE}, 2 bits.
  - Constants MIN_N=2, MAX_N=32.
  - Function cw(N) returning the counter width.
- Sub-module fa_cell: a single-bit full adder built from two half_adder instances and an OR of their carries.
  - Ports: x, y, ci, s, co.
  - Purely structural, no state.
- Controller: one always block for the state/counter/shift registers, plus a combinational next-state block.
- Elaboration check: N outside MIN_N..MAX_N raises a fatal error.

Test Plan:
- N=8: a=8'h5A, b=8'h3C, cin=0, start at edge k.
  - busy high from edge k; done at edge k+8.
  - sum=8'h96, cout=0.
- N=8: a=8'hFF, b=8'h01, cin=0.
  - sum=8'h00, cout=1; done is a single cycle.
- N=8: a=8'hFF, b=8'hFF, cin=1.
  - sum=8'hFF, cout=1.
  - sum/cout hold unchanged for 5 idle cycles afterwards.
- N=8: start 8'h10+8'h20, then at edge k+3 pulse start with a=8'hFF, b=8'hFF.
  - Second request is ignored; result sum=8'h30, cout=0.
- N=8: start 8'hAA+8'h55; assert rst at edge k+4.
  - busy=done=sum=cout=0 immediately; no done pulse.
  - Next start 8'h01+8'h01 gives sum=8'h02.
- N=4: start held high for 30 cycles with a=4'h9, b=4'h8, cin=1.
  - done pulses every 6 cycles; each result is sum=4'h2, cout=1.
- Every scenario: a reference model checks {cout,sum}==a+b+cin on every done pulse.
